// File: rtl/fc_vector_tx.sv
// Ping-pong vector transmitter: host fills one bank while the other streams out over valid/ready.
// Optional macro FC_TX_LAST_EN adds an output_last port flagging the final element of each vector.
module fc_vector_tx #(
  parameter int N = 8,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic signed [T-1:0]  wr_data,
  input  logic                 commit,
  output logic                 commit_ready,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic signed [T-1:0]  output_data,
`ifdef FC_TX_LAST_EN
  output logic                 output_last,
`endif
  output logic                 busy
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  logic signed [T-1:0] bank_q [2][N];
  logic signed [T-1:0] bank_d [2][N];
  logic [1:0]          bank_full_q, bank_full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [AW-1:0]       cnt_q, cnt_d;

  logic wr_ok;
  logic commit_ok;
  logic handshake;

  assign commit_ready = !bank_full_q[wr_bank_q];
  assign output_valid = bank_full_q[rd_bank_q];
  assign output_data  = output_valid ? bank_q[rd_bank_q][cnt_q] : '0;
  assign busy         = |bank_full_q;
`ifdef FC_TX_LAST_EN
  assign output_last  = output_valid && (cnt_q == CNT_LAST);
`endif

  assign wr_ok     = wr_en && commit_ready && (int'(wr_addr) < N);
  assign commit_ok = commit && commit_ready;
  assign handshake = output_valid && output_ready;

  always_comb begin
    bank_d = bank_q;
    if (wr_ok) begin
      bank_d[wr_bank_q][wr_addr] = wr_data;
    end
  end

  // Commit and final-element handshake always touch different banks, so both may apply.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cnt_d       = cnt_q;
    if (commit_ok) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = !wr_bank_q;
    end
    if (handshake) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d                  = '0;
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      cnt_q       <= cnt_d;
    end
  end

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_fc_vector_tx.sv
// Directed self-checking bench for fc_vector_tx; output_last is checked when FC_TX_LAST_EN is defined.
module tb_fc_vector_tx;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic signed [15:0] wr_data;
  logic              commit;
  logic              commit_ready;
  logic              output_valid;
  logic              output_ready;
  logic signed [15:0] output_data;
  logic              busy;
`ifdef FC_TX_LAST_EN
  logic              output_last;
`endif

  int nAsserts = 0;
  int nFailures = 0;

  fc_vector_tx #(.N(8), .T(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .commit_ready (commit_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
`ifdef FC_TX_LAST_EN
    .output_last  (output_last),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFailures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, int'(output_valid), 0);
    checkOutput({tag, "_cready"}, int'(commit_ready), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_data"}, int'(output_data), 0);
`ifdef FC_TX_LAST_EN
    checkOutput({tag, "_last"}, int'(output_last), 0);
`endif
  endtask

  task automatic checkBeat(input string tag, input int expData, input bit expLast);
    checkOutput({tag, "_valid"}, int'(output_valid), 1);
    checkOutput({tag, "_data"}, int'(output_data), expData);
`ifdef FC_TX_LAST_EN
    checkOutput({tag, "_last"}, int'(output_last), int'(expLast));
`endif
  endtask

  task automatic writeVector(input int v[8], input bit doCommit);
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 16'(v[i]);
      tick();
    end
    wr_en = 1'b0;
    if (doCommit) begin
      commit = 1'b1;
      tick();
      commit = 1'b0;
    end
  endtask

  initial begin
    int vecA[8];
    int vecB[8];
    int expStream[16];
    int idx;

    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit = 1'b0;
    output_ready = 1'b0;
    tick();
    tick();
    checkIdle("reset_held");
    reset = 1'b0;
    tick();
    checkIdle("reset_released");

    // Single vector with downstream always ready
    $display("[TB] single vector");
    output_ready = 1'b1;
    vecA = '{81, -94, 1, 75, 109, 60, 58, -50};
    writeVector(vecA, 1'b0);
    checkOutput("t1_valid_before_commit", int'(output_valid), 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkBeat($sformatf("t1_beat%0d", i), vecA[i], i == 7);
      tick();
    end
    checkIdle("t1_after");

    // Back-to-back vectors, B committed while A streams
    $display("[TB] back-to-back vectors");
    output_ready = 1'b0;
    vecA = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecB = '{-1, -2, -3, -4, -5, -6, -7, -8};
    writeVector(vecA, 1'b1);
    writeVector(vecB, 1'b0);
    output_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkBeat($sformatf("t2_beat%0d", i), (i < 8) ? vecA[i] : vecB[i - 8], (i % 8) == 7);
      checkOutput($sformatf("t2_cready%0d", i), int'(commit_ready), (i >= 3 && i <= 7) ? 0 : 1);
      checkOutput($sformatf("t2_busy%0d", i), int'(busy), 1);
      commit = (i == 2);
      tick();
    end
    commit = 1'b0;
    checkIdle("t2_after");

    // Stall then toggle ready
    $display("[TB] stall and toggling ready");
    output_ready = 1'b0;
    writeVector(vecA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkBeat($sformatf("t3_stall%0d", i), 1, 1'b0);
      tick();
    end
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      output_ready = (c % 2 == 0);
      checkBeat($sformatf("t3_cyc%0d", c), vecA[idx], idx == 7);
      tick();
      if (output_ready) idx++;
    end
    output_ready = 1'b0;
    checkIdle("t3_after");

    // Writes and commits ignored while both banks are full
    $display("[TB] full banks ignore host");
    vecA = '{100, -200, 300, -400, 500, -600, 700, -800};
    vecB = '{7, -7, 77, -77, 777, -777, 32767, -32768};
    writeVector(vecA, 1'b1);
    writeVector(vecB, 1'b1);
    checkOutput("t4_cready_full", int'(commit_ready), 0);
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 16'sd123;
    commit = 1'b1;
    tick();
    wr_en = 1'b0;
    commit = 1'b0;
    checkOutput("t4_cready_still", int'(commit_ready), 0);
    output_ready = 1'b1;
    for (int i = 0; i < 16; i++) expStream[i] = (i < 8) ? vecA[i] : vecB[i - 8];
    for (int i = 0; i < 16; i++) begin
      checkBeat($sformatf("t4_beat%0d", i), expStream[i], (i % 8) == 7);
      tick();
    end
    checkIdle("t4_after");

    // Reset mid-vector, then a fresh vector with the final write merged into the commit
    $display("[TB] reset mid-transfer");
    output_ready = 1'b0;
    vecA = '{10, 20, 30, 40, 50, 60, 70, 80};
    writeVector(vecA, 1'b1);
    output_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkBeat($sformatf("t5_pre%0d", i), vecA[i], 1'b0);
      tick();
    end
    reset = 1'b1;
    #2;
    checkIdle("t5_reset");
    tick();
    reset = 1'b0;
    vecB = '{5, 6, 7, 8, 9, 10, 11, 12};
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      wr_addr = 3'(i);
      wr_data = 16'(vecB[i]);
      tick();
    end
    wr_addr = 3'd7;
    wr_data = 16'(vecB[7]);
    commit = 1'b1;
    tick();
    wr_en = 1'b0;
    commit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkBeat($sformatf("t5_beat%0d", i), vecB[i], i == 7);
      tick();
    end
    checkIdle("t5_after");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule

// File: doc/fc_vector_tx.md
Name: fc_vector_tx

Overview:
- Streaming transmitter that drives the input side of an fc layer: valid/ready handshake, N signed T-bit elements per vector.
- Host writes a vector element-by-element into a ping-pong register buffer, then commits it.
- The block streams committed vectors out in element order 0..N-1 while the host fills the other bank.
- Sits between a host/loader and the layer's input_valid / input_ready / input_data ports.

Parameters:
N, 8, elements per vector; N >= 2.
T, 16, element width in bits, signed.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  write strobe for one element into the current write bank.
wr_addr  input  $clog2(N)  element index 0..N-1.
wr_data  input  T  signed element value.
commit  input  1  marks the write bank as a complete vector.
commit_ready  output  1  write bank is free; wr_en and commit are accepted.
output_valid  output  1  element available on output_data.
output_ready  input  1  downstream accepts the element.
output_data  output  T  signed element; drives the layer's input_data.
busy  output  1  at least one bank is full.

Behaviour:
- State: two banks of N x T registers; bank_full[1:0]; wr_bank; rd_bank; element counter cnt (0..N-1).
- Reset (asynchronous, immediate): bank_full=0, wr_bank=0, rd_bank=0, cnt=0.
  - Resulting outputs: output_valid=0, commit_ready=1, busy=0, output_data=0.
  - Bank contents are not reset.
  - Reset during a transfer abandons the vector; no partial continuation afterwards.
- commit_ready = !bank_full[wr_bank], combinational from registered state.
- Write side:
  - wr_en with commit_ready=1 writes wr_data into bank[wr_bank][wr_addr] at the clock edge.
  - wr_en with commit_ready=0 is ignored; bank contents are unchanged.
  - wr_addr >= N is ignored (only possible when N is not a power of two).
- Commit:
  - commit with commit_ready=1 sets bank_full[wr_bank] and toggles wr_bank at the edge.
  - commit with commit_ready=0 is ignored.
  - wr_en and commit in the same cycle: the write lands in the bank being committed.
- Read side:
  - output_valid = bank_full[rd_bank].
  - output_data = bank[rd_bank][cnt] while output_valid=1; otherwise 0.
  - Latency: commit accepted at edge k gives output_valid=1 in the cycle after edge k, provided the read bank was empty.
- Handshake (output_valid && output_ready at an edge):
  - If cnt < N-1: cnt increments.
  - If cnt == N-1: cnt <- 0, bank_full[rd_bank] cleared, rd_bank toggles.
  - If the other bank is already full, output_valid stays 1 and the next vector's element 0 follows with no bubble.
- Valid is never withdrawn without a handshake. output_data is stable while output_valid=1 and output_ready=0.
- A commit and a final-element handshake in the same edge both take effect; they always target different banks.
- When both banks are full, commit_ready=0 in that cycle even if the read bank frees at the same edge (no combinational ready path).
- busy = |bank_full.
- Vectors leave in commit order; no reordering, no drops.

Optional Feature:
- Macro FC_TX_LAST_EN.
- Defined: adds output port output_last (1 bit), equal to output_valid && (cnt == N-1). Reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset, write bank0 elements 0..7 = {81,-94,1,75,109,60,58,-50}, commit, output_ready=1 constantly -> output_valid rises the cycle after the commit; eight consecutive beats carry exactly those values; then output_valid=0, busy=0.
- Commit vector A = {1..8}, commit vector B = {-1..-8} while A streams, output_ready=1 -> 16 beats back-to-back with no bubble; commit_ready=0 only while both banks are full.
- Commit vector A, hold output_ready=0 for 5 cycles, then toggle output_ready every cycle -> output_data holds 1 through the stall; each element is emitted exactly once, in order.
- Fill and commit both banks, then assert wr_en with addr 0, data 123, plus commit -> both ignored; the streamed data equals the original two vectors.
- Assert reset after 3 beats of vector {10,20,...,80} -> outputs return to reset values immediately; the next committed vector {5,...} starts at element 0.
- With FC_TX_LAST_EN defined: output_last is high only on the beat carrying element 7 of each vector, including during back-to-back vectors.
